// File: rtl/iter_shifter.sv
// Iterative 16-bit shifter/rotator: applies one power-of-two stage (1, 2, 4, 8)
// per cycle, selected by the captured count bits, and accumulates the result in data_q.
module iter_shifter #(
  parameter int EARLY_EXIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  input  logic [1:0]  oper,
  output logic [15:0] out,
  output logic        ready,
  output logic        done
);

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   data_q;
  logic [3:0]          cnt_q;
  logic [1:0]          oper_q;
  logic [1:0]          k_q;

  logic [DATA_W-1:0]   stage_res;
  logic [3:0]          cnt_hi;
  logic                last;
  logic                accept;

  // One shift/rotate stage by 2^k; all results are taken mod 16 bits.
  function automatic logic [DATA_W-1:0] stage_fn(
    input logic [DATA_W-1:0] d,
    input logic [1:0]        k,
    input logic [1:0]        op
  );
    logic signed [DATA_W-1:0] sd;
    logic [4:0]               amt;
    logic [DATA_W-1:0]        r;
    sd  = $signed(d);
    amt = 5'd1 << k;
    case (op)
      OP_ROL:  r = (d << amt) | (d >> (5'd16 - amt));
      OP_SLL:  r = d << amt;
      OP_SRA:  r = sd >>> amt;
      default: r = d >> amt;
    endcase
    return r;
  endfunction

  assign stage_res = cnt_q[k_q] ? stage_fn(data_q, k_q, oper_q) : data_q;

  // Count bits above the current stage; zero means every remaining stage is a pass-through.
  assign cnt_hi = cnt_q >> ({1'b0, k_q} + 3'd1);
  assign last   = (k_q == 2'd3) || ((EARLY_EXIT != 0) && (cnt_hi == 4'd0));

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign accept = start && ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture on accept, then step one stage per cycle; out only moves on the final stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      oper_q  <= '0;
      k_q     <= '0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in;
        cnt_q  <= cnt;
        oper_q <= oper;
        k_q    <= 2'd0;
      end else if (state_q == SHIFT) begin
        data_q <= stage_res;
        k_q    <= k_q + 2'd1;
        if (last) out <= stage_res;
      end
    end
  end

endmodule
